// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multicycle control FSM with bus watchdog and trapping
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        busWe,
  output logic        busReq,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        trap,
  output logic [1:0]  trapCause
);

  localparam int unsigned WDW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd_cnt;
  logic [1:0]     cause_q;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           instr30;
  logic           op_legal;
  logic           timeout_hit;
  logic           unused_instr_bits;

  assign opcode  = instrCode[6:0];
  assign funct3  = instrCode[14:12];
  assign instr30 = instrCode[30];
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_B, OP_LUI, OP_AUI, OP_JAL, OP_JALR, OP_S, OP_L: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // busReady in the final watchdog cycle still completes the transfer
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST) && !busReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      wd_cnt  <= '0;
      cause_q <= 2'b00;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:    state <= R_EXE;
            OP_I:    state <= I_EXE;
            OP_B:    state <= B_EXE;
            OP_LUI:  state <= LU_EXE;
            OP_AUI:  state <= AU_EXE;
            OP_JAL:  state <= J_EXE;
            OP_JALR: state <= JL_EXE;
            OP_S:    state <= S_EXE;
            OP_L:    state <= L_EXE;
            default: begin
              if (HALT_ON_ILLEGAL) begin
                state   <= TRAP;
                cause_q <= CAUSE_ILLEGAL;
              end else begin
                state <= FETCH;
              end
            end
          endcase
        end
        R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE: state <= FETCH;
        S_EXE: begin
          state  <= S_MEM;
          wd_cnt <= '0;
        end
        L_EXE: begin
          state  <= L_MEM;
          wd_cnt <= '0;
        end
        S_MEM, L_MEM: begin
          if (busReady) begin
            state <= (state == S_MEM) ? FETCH : L_WB;
          end else if (timeout_hit) begin
            state   <= TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        L_WB:    state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode; reset forces FETCH asynchronously so every output drops at once
  always_comb begin
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    busReq        = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    trap          = 1'b0;
    case (state)
      DECODE: PCEn = !op_legal && !HALT_ON_ILLEGAL;
      R_EXE: begin
        regFileWe  = 1'b1;
        PCEn       = 1'b1;
        aluControl = {instr30, funct3};
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        PCEn         = 1'b1;
        // only the shift-right immediates use instr[30] as an opcode bit
        aluControl   = (funct3 == 3'b101) ? {instr30, funct3} : {1'b0, funct3};
      end
      B_EXE: begin
        branch     = 1'b1;
        PCEn       = 1'b1;
        aluControl = {instr30, funct3};
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        PCEn          = 1'b1;
        RFWDSrcMuxSel = 3'b010;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        PCEn          = 1'b1;
        RFWDSrcMuxSel = 3'b011;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        PCEn          = 1'b1;
        RFWDSrcMuxSel = 3'b100;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        jalr          = 1'b1;
        PCEn          = 1'b1;
        RFWDSrcMuxSel = 3'b100;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        busReq       = 1'b1;
        PCEn         = busReady;
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        busReq        = 1'b1;
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        PCEn          = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign trapCause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;

  logic        pc_a, we_a, src_a, bwe_a, breq_a, br_a, j_a, jr_a, tr_a;
  logic [3:0]  alu_a;
  logic [2:0]  rf_a;
  logic [1:0]  tc_a;
  logic        pc_b, we_b, src_b, bwe_b, breq_b, br_b, j_b, jr_b, tr_b;
  logic [3:0]  alu_b;
  logic [2:0]  rf_b;
  logic [1:0]  tc_b;

  int n_cmp = 0;
  int n_err = 0;

  string       tagq[$];
  logic [35:0] expq[$];

  always #5 clk = ~clk;

  // A: short watchdog, halts on illegal; B: watchdog disabled, illegal retires as NOP
  multicycle_control_unit #(.TIMEOUT_CYCLES(4), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .PCEn(pc_a), .regFileWe(we_a), .aluControl(alu_a), .aluSrcMuxSel(src_a),
    .busWe(bwe_a), .busReq(breq_a), .RFWDSrcMuxSel(rf_a), .branch(br_a),
    .jal(j_a), .jalr(jr_a), .trap(tr_a), .trapCause(tc_a)
  );

  multicycle_control_unit #(.TIMEOUT_CYCLES(0), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .PCEn(pc_b), .regFileWe(we_b), .aluControl(alu_b), .aluSrcMuxSel(src_b),
    .busWe(bwe_b), .busReq(breq_b), .RFWDSrcMuxSel(rf_b), .branch(br_b),
    .jal(j_b), .jalr(jr_b), .trap(tr_b), .trapCause(tc_b)
  );

  logic [17:0] obs_a, obs_b;
  assign obs_a = {pc_a, we_a, alu_a, src_a, bwe_a, breq_a, rf_a, br_a, j_a, jr_a, tr_a, tc_a};
  assign obs_b = {pc_b, we_b, alu_b, src_b, bwe_b, breq_b, rf_b, br_b, j_b, jr_b, tr_b, tc_b};

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic pc, input logic we, input logic [3:0] alu,
                                     input logic src, input logic bwe, input logic breq,
                                     input logic [2:0] rf, input logic br, input logic j,
                                     input logic jr, input logic tr, input logic [1:0] tc);
    return {pc, we, alu, src, bwe, breq, rf, br, j, jr, tr, tc};
  endfunction

  localparam logic [17:0] Z = 18'h0;

  logic [17:0] LX, LM, LW, SX, SM0, SM1, TR01, TR10, NOPD;

  task automatic cyc(input logic rst, input logic br, input logic [31:0] ins,
                     input string tag, input logic [17:0] ea, input logic [17:0] eb);
    @(negedge clk);
    reset     = rst;
    busReady  = br;
    instrCode = ins;
    tagq.push_back(tag);
    expq.push_back({ea, eb});
  endtask

  task automatic run3(input string tag, input logic [31:0] ins, input logic [17:0] ex);
    cyc(1'b1, 1'b0, ins, {tag, "/F"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/D"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/X"}, ex, ex);
  endtask

  task automatic run_load(input string tag, input logic [31:0] ins, input int nw);
    cyc(1'b1, 1'b0, ins, {tag, "/F"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/D"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/LX"}, LX, LX);
    for (int i = 0; i < nw; i++) cyc(1'b1, 1'b0, ins, {tag, "/LMw"}, LM, LM);
    cyc(1'b1, 1'b1, ins, {tag, "/LMr"}, LM, LM);
    cyc(1'b1, 1'b0, ins, {tag, "/WB"}, LW, LW);
  endtask

  task automatic run_store(input string tag, input logic [31:0] ins, input int nw);
    cyc(1'b1, 1'b0, ins, {tag, "/F"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/D"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/SX"}, SX, SX);
    for (int i = 0; i < nw; i++) cyc(1'b1, 1'b0, ins, {tag, "/SMw"}, SM0, SM0);
    cyc(1'b1, 1'b1, ins, {tag, "/SMr"}, SM1, SM1);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins);
    cyc(1'b1, 1'b0, ins, {tag, "/F"}, Z, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/D"}, Z, NOPD);
    cyc(1'b1, 1'b0, ins, {tag, "/T1"}, TR01, Z);
    cyc(1'b1, 1'b0, ins, {tag, "/T2"}, TR01, NOPD);
    cyc(1'b0, 1'b0, ins, {tag, "/rst"}, Z, Z);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() != 0) begin
        logic [35:0] e;
        string t;
        e = expq.pop_front();
        t = tagq.pop_front();
        check({t, "_a"}, obs_a, e[35:18]);
        check({t, "_b"}, obs_b, e[17:0]);
      end
    end
  end

  initial begin
    LX   = mk(0, 0, 4'h0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 2'b00);
    LM   = mk(0, 0, 4'h0, 1, 0, 1, 3'b001, 0, 0, 0, 0, 2'b00);
    LW   = mk(1, 1, 4'h0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 2'b00);
    SX   = mk(0, 0, 4'h0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00);
    SM0  = mk(0, 0, 4'h0, 1, 1, 1, 3'b000, 0, 0, 0, 0, 2'b00);
    SM1  = mk(1, 0, 4'h0, 1, 1, 1, 3'b000, 0, 0, 0, 0, 2'b00);
    TR01 = mk(0, 0, 4'h0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b01);
    TR10 = mk(0, 0, 4'h0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10);
    NOPD = mk(1, 0, 4'h0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);

    reset     = 1'b0;
    busReady  = 1'b0;
    instrCode = $urandom;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, "reset", Z, Z);

    run3("add",   32'h002081B3, mk(1, 1, 4'b0000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    run3("sub",   32'h402081B3, mk(1, 1, 4'b1000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    run3("srai",  32'h4032D293, mk(1, 1, 4'b1101, 1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    run3("addi30", 32'h40000093, mk(1, 1, 4'b0000, 1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    run3("bne",   32'h00209463, mk(1, 0, 4'b0001, 0, 0, 0, 3'b000, 1, 0, 0, 0, 2'b00));
    run3("lui",   32'h123450B7, mk(1, 1, 4'b0000, 0, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00));
    run3("auipc", 32'h00001097, mk(1, 1, 4'b0000, 0, 0, 0, 3'b011, 0, 0, 0, 0, 2'b00));
    run3("jal",   32'h008000EF, mk(1, 1, 4'b0000, 0, 0, 0, 3'b100, 0, 1, 0, 0, 2'b00));
    run3("jalr",  32'h000080E7, mk(1, 1, 4'b0000, 0, 0, 0, 3'b100, 0, 1, 1, 0, 2'b00));

    run_load("lw0", 32'h00012083, 0);
    run_load("lw2", 32'h00012083, 2);
    run_store("sw0", 32'h00112023, 0);
    run_store("sw3", 32'h00112023, 3);

    // store that never completes: A traps after 4 request cycles, B keeps waiting
    cyc(1'b1, 1'b0, 32'h00112023, "swto/F", Z, Z);
    cyc(1'b1, 1'b0, 32'h00112023, "swto/D", Z, Z);
    cyc(1'b1, 1'b0, 32'h00112023, "swto/SX", SX, SX);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h00112023, "swto/SMw", SM0, SM0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h00112023, "swto/T", TR10, SM0);
    #4;
    reset = 1'b0;
    #1;
    check("swto_async_rst", {13'h0, breq_a, breq_b, tr_a, tc_a}, 18'h0);
    cyc(1'b0, 1'b0, 32'h00112023, "swto/rst", Z, Z);

    // reset mid-load with busReq high
    cyc(1'b1, 1'b0, 32'h00012083, "lwrst/F", Z, Z);
    cyc(1'b1, 1'b0, 32'h00012083, "lwrst/D", Z, Z);
    cyc(1'b1, 1'b0, 32'h00012083, "lwrst/LX", LX, LX);
    cyc(1'b1, 1'b0, 32'h00012083, "lwrst/LMw", LM, LM);
    #4;
    reset = 1'b0;
    #1;
    check("lw_async_rst", {16'h0, breq_a, breq_b}, 18'h0);
    cyc(1'b0, 1'b0, 32'h00012083, "lwrst/rst", Z, Z);

    run_illegal("ill7f", 32'h0000007F);
    run_illegal("ill00", 32'h00000000);
    run3("add2", 32'h002081B3, mk(1, 1, 4'b0000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));

    @(negedge clk);
    #4;
    check("sb_drained", 18'(expq.size()), 18'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM for the RV32I core: decodes the registered instruction word and sequences fetch, decode, execute, memory and write-back over several cycles, with a wait-state-aware bus handshake toward the APB master. It generalises the single-cycle decoder with the following features:
- per-state control outputs;
- a parametrised bus-timeout watchdog;
- illegal-opcode and bus-timeout trapping.

It sits between the instruction register and the datapath muxes and regfile, and drives the PC enable.

## Interface
- TIMEOUT_CYCLES, 16: maximum `*_MEM` cycles waiting for busReady before a timeout trap; 0 disables the watchdog.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as a NOP.
- clk  input  1  core clock, all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- instrCode  input  32  instruction register contents, stable from DECODE until return to FETCH.
- busReady  input  1  bus transfer complete (APB PREADY), sampled in `*_MEM` states.
- PCEn  output  1  PC register update enable.
- regFileWe  output  1  register-file write enable.
- aluControl  output  4  ALU operation, {instr[30], funct3}.
- aluSrcMuxSel  output  1  1 = immediate operand.
- busWe  output  1  bus write.
- busReq  output  1  bus transfer request.
- RFWDSrcMuxSel  output  3  write-back source: 000 ALU, 001 bus read data, 010 LUI immediate, 011 AUIPC, 100 PC+4.
- branch  output  1  branch compare path enable.
- jal  output  1  jump target select.
- jalr  output  1  register-relative jump select.
- trap  output  1  core halted.
- trapCause  output  2  00 none, 01 illegal opcode, 10 bus timeout.

## Operation
- States: FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
- Transitions:
  - FETCH -> DECODE unconditionally.
  - DECODE dispatches on opcode:
    - 0110011 -> R_EXE
    - 0010011 -> I_EXE
    - 1100011 -> B_EXE
    - 0110111 -> LU_EXE
    - 0010111 -> AU_EXE
    - 1101111 -> J_EXE
    - 1100111 -> JL_EXE
    - 0100011 -> S_EXE
    - 0000011 -> L_EXE
    - anything else -> TRAP if HALT_ON_ILLEGAL, otherwise FETCH with PCEn=1 for that DECODE cycle.
  - R/I/B/LU/AU/J/JL_EXE -> FETCH.
  - S_EXE -> S_MEM.
  - S_MEM -> FETCH on busReady.
  - L_EXE -> L_MEM.
  - L_MEM -> L_WB on busReady.
  - L_WB -> FETCH.
  - TRAP is absorbing; only reset leaves it.
- Outputs are Moore on state, plus instrCode decode for aluControl. Every output not listed below is 0.
  - FETCH, DECODE: all outputs 0.
  - R_EXE: regFileWe, PCEn; aluControl = {instr[30], funct3}.
  - I_EXE: regFileWe, aluSrcMuxSel, PCEn; aluControl = {instr[30], funct3} when funct3=101 (SRAI/SRLI), else {0, funct3}.
  - B_EXE: branch, PCEn; aluControl = {instr[30], funct3}.
  - LU_EXE: regFileWe, PCEn, RFWDSrc=010.
  - AU_EXE: regFileWe, PCEn, RFWDSrc=011.
  - J_EXE: regFileWe, jal, PCEn, RFWDSrc=100.
  - JL_EXE: regFileWe, jal, jalr, PCEn, RFWDSrc=100.
  - S_EXE: aluSrcMuxSel, busWe.
  - S_MEM: aluSrcMuxSel, busWe, busReq; PCEn = busReady.
  - L_EXE: aluSrcMuxSel, RFWDSrc=001.
  - L_MEM: aluSrcMuxSel, RFWDSrc=001, busReq.
  - L_WB: regFileWe, aluSrcMuxSel, RFWDSrc=001, PCEn.
  - TRAP: trap=1, all other outputs 0 except trapCause.
- aluControl = 4'b0000 (ADD) in every state not listed above.
- Watchdog:
  - Counter of width clog2(TIMEOUT_CYCLES+1); cleared on entry to each `*_MEM` state; increments each `*_MEM` cycle with busReady=0.
  - When the count equals TIMEOUT_CYCLES-1 and busReady=0, the next state is TRAP with trapCause=10.
  - busReady=1 in the same cycle wins over timeout.
- trapCause is a register: loaded when entering TRAP, held until reset.

## Timing
- Reset (reset=0, asynchronous): state=FETCH, watchdog=0, trapCause=00, all outputs 0. Release is synchronous to the next clk edge.
- Reset asserted mid-operation (including in `*_MEM` with busReq high) forces FETCH immediately; busReq drops combinationally.
- Cycles per instruction with zero wait states:
  - R/I/B/LU/AU/J/JL: 3.
  - Store: 4.
  - Load: 5.
  - Each wait state adds 1 cycle to store and load.
- PCEn is high for exactly one cycle per retired instruction; never in TRAP.
- busReq is held high continuously in `*_MEM` until the busReady cycle inclusive. busWe is stable for the whole store request.
- TIMEOUT_CYCLES=N: with busReady never asserted, busReq stays high for N cycles, then trap rises on the following edge.

## Test plan
- Reset: hold reset=0 with random instrCode -> all outputs 0, state FETCH; release -> DECODE after 1 edge.
- ADD x3,x1,x2 (0x002081B3) -> FETCH, DECODE, R_EXE; in R_EXE regFileWe=1, PCEn=1, aluControl=0000; back to FETCH; 3 cycles total.
- SRAI x5,x5,3 (0x4032D293) -> aluControl=1101. ADDI with instr[30]=1 (0x40000093) -> aluControl=0000.
- LW x1,0(x2) (0x00012083) with busReady after 2 wait states -> busReq high 3 cycles, then L_WB with regFileWe=1, RFWDSrc=001, PCEn=1; 7 cycles total.
- SW with busReady=0 forever, TIMEOUT_CYCLES=4 -> busReq high 4 cycles, then trap=1, trapCause=10, PCEn never asserted; reset clears trap.
- Opcode 0x0000007F: HALT_ON_ILLEGAL=1 -> trap=1, trapCause=01 after DECODE; HALT_ON_ILLEGAL=0 -> PCEn=1 in DECODE, regFileWe=0, return to FETCH.
